cache_control: RTL and testbench

Sequencing FSM for the direct-mapped, write-back, 8-set L1 cache. It decodes CPU read/write requests and drives load strobes for the valid, tag, dirty and data arrays. It runs line writeback and fill transactions on physical memory and keeps saturating hit/miss counters for performance reporting. It sits between the CPU memory port and the cache datapath; hit and dirty status come back from the datapath.

---
 rtl/cache_types.sv | 17 +
 rtl/sat_counter.sv | 19 +
 rtl/cache_control.sv | 140 ++++++++++++++
 tb/tb_cache_control.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_types.sv
// rtl/cache_types.sv - shared state encoding and mux select constants for the L1 cache controller
package cache_types;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHECK     = 2'd1,
    WRITEBACK = 2'd2,
    FILL      = 2'd3
  } state_t;

  localparam logic SEL_CPU  = 1'b0;
  localparam logic SEL_PMEM = 1'b1;

  localparam logic ADDR_CPU = 1'b0;
  localparam logic ADDR_WB  = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_control.sv
// rtl/cache_control.sv - sequencing FSM for the direct-mapped write-back L1 cache:
// decodes CPU requests, runs writeback/fill on physical memory, counts hits and misses.
module cache_control
  import cache_types::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic                 mem_resp,
  input  logic                 hit,
  input  logic                 dirty,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic                 pmem_resp,
  output logic                 valid_load,
  output logic                 tag_load,
  output logic                 dirty_load,
  output logic                 dirty_in,
  output logic                 data_load,
  output logic                 data_sel,
  output logic                 addr_sel,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  state_t r_state;
  state_t w_next;
  logic   r_refill;
  logic   w_req;
  logic   w_hit_inc;
  logic   w_miss_inc;

  assign w_req = mem_read | mem_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Marks the CHECK that follows a fill so its guaranteed hit is not counted as a first-try hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_refill <= 1'b0;
    end else if ((r_state == FILL) && pmem_resp) begin
      r_refill <= 1'b1;
    end else if (r_state == CHECK) begin
      r_refill <= 1'b0;
    end
  end

  always_comb begin
    w_next     = r_state;
    mem_resp   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    valid_load = 1'b0;
    tag_load   = 1'b0;
    dirty_load = 1'b0;
    dirty_in   = 1'b0;
    data_load  = 1'b0;
    data_sel   = SEL_CPU;
    addr_sel   = ADDR_CPU;
    w_hit_inc  = 1'b0;
    w_miss_inc = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_next = CHECK;
        end
      end

      CHECK: begin
        if (!w_req) begin
          w_next = IDLE;
        end else if (hit) begin
          mem_resp  = 1'b1;
          w_hit_inc = ~r_refill;
          w_next    = IDLE;
          if (mem_write) begin
            data_load  = 1'b1;
            data_sel   = SEL_CPU;
            dirty_load = 1'b1;
            dirty_in   = 1'b1;
          end
        end else begin
          w_miss_inc = 1'b1;
          w_next     = dirty ? WRITEBACK : FILL;
        end
      end

      WRITEBACK: begin
        pmem_write = 1'b1;
        addr_sel   = ADDR_WB;
        if (pmem_resp) begin
          w_next = FILL;
        end
      end

      FILL: begin
        pmem_read = 1'b1;
        addr_sel  = ADDR_CPU;
        if (pmem_resp) begin
          data_load  = 1'b1;
          data_sel   = SEL_PMEM;
          tag_load   = 1'b1;
          valid_load = 1'b1;
          dirty_load = 1'b1;
          dirty_in   = 1'b0;
          w_next     = CHECK;
        end
      end

      default: begin
        w_next = IDLE;
      end
    endcase
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_hit_inc),
    .count (hit_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_miss_inc),
    .count (miss_count)
  );

endmodule

// File: tb/tb_cache_control.sv
// tb/tb_cache_control.sv - self-checking bench for cache_control with a datapath model,
// a pmem responder and a response scoreboard.
module tb_cache_control;
  import cache_types::*;

  localparam int CNT = 3;
  localparam int CMAX = (1 << CNT) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mem_read = 1'b0;
  logic mem_write = 1'b0;
  logic pmem_resp = 1'b0;
  logic mem_resp, hit, dirty, pmem_read, pmem_write;
  logic valid_load, tag_load, dirty_load, dirty_in, data_load, data_sel, addr_sel;
  logic [CNT-1:0] hit_count, miss_count;

  logic [6:0] addr = '0;
  logic       model_clr = 1'b1;
  logic       dm_valid [8];
  logic       dm_dirty [8];
  logic [3:0] dm_tag   [8];
  logic [9:0] w_strb;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cache_control #(.CNT_WIDTH(CNT)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_resp   (mem_resp),
    .hit        (hit),
    .dirty      (dirty),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_resp  (pmem_resp),
    .valid_load (valid_load),
    .tag_load   (tag_load),
    .dirty_load (dirty_load),
    .dirty_in   (dirty_in),
    .data_load  (data_load),
    .data_sel   (data_sel),
    .addr_sel   (addr_sel),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  assign w_strb = {mem_resp, pmem_read, pmem_write, valid_load, tag_load,
                   dirty_load, dirty_in, data_load, data_sel, addr_sel};

  // Datapath arrays: 8 sets addressed by addr[2:0], tag addr[6:3].
  assign hit   = dm_valid[addr[2:0]] && (dm_tag[addr[2:0]] == addr[6:3]);
  assign dirty = dm_dirty[addr[2:0]];

  always @(posedge clk) begin
    if (model_clr) begin
      for (int i = 0; i < 8; i++) begin
        dm_valid[i] <= 1'b0;
        dm_dirty[i] <= 1'b0;
        dm_tag[i]   <= '0;
      end
    end else begin
      if (valid_load) dm_valid[addr[2:0]] <= 1'b1;
      if (tag_load)   dm_tag[addr[2:0]]   <= addr[6:3];
      if (dirty_load) dm_dirty[addr[2:0]] <= dirty_in;
    end
  end

  typedef struct {
    int start;
    int lat;
    int rdc;
    int wrc;
    bit is_write;
  } sb_t;

  typedef struct {
    bit         rd;
    bit         wr;
    logic [6:0] a;
    int         lat;
    int         rdc;
    int         wrc;
    int         hit_inc;
    int         miss_inc;
  } vec_t;

  sb_t  sb[$];
  vec_t vecs[10];

  int   acc_rd = 0, acc_wr = 0, acc_fill = 0, resp_cnt = 0;
  bit   auto_resp = 1'b1;
  logic [1:0] last_kind = 2'b00;
  int   kcnt = 0;
  int   fill_delay = 3, wb_delay = 2;
  int   exp_hit = 0, exp_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic monitor();
    sb_t e;
    if (pmem_read || pmem_write) chk("pmem_exclusive", 32'(pmem_read & pmem_write), 0);
    if (sb.size() > 0) begin
      if (pmem_write) begin
        acc_wr++;
        chk("wb_addr_sel", 32'(addr_sel), 32'(ADDR_WB));
      end
      if (pmem_read) begin
        acc_rd++;
        chk("fill_addr_sel", 32'(addr_sel), 32'(ADDR_CPU));
      end
      if (data_load && data_sel) begin
        acc_fill++;
        chk("fill_strobes", 32'({tag_load, valid_load, dirty_load, dirty_in}), 32'b1110);
      end
    end
    if (mem_resp) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("latency", cyc - e.start, e.lat);
        chk("fill_cycles", acc_rd, e.rdc);
        chk("wb_cycles", acc_wr, e.wrc);
        chk("fill_loads", acc_fill, (e.rdc > 0) ? 1 : 0);
        chk("resp_strobes",
            32'({data_load, data_sel, dirty_load, dirty_in, pmem_read, pmem_write, valid_load, tag_load}),
            e.is_write ? 32'b1011_0000 : 32'b0);
      end
      acc_rd = 0; acc_wr = 0; acc_fill = 0;
      resp_cnt++;
    end
  endtask

  // One clock: pmem responder at the falling edge, then sample 2 ns later.
  task automatic tick();
    logic [1:0] cur;
    @(negedge clk);
    if (auto_resp) begin
      cur = {pmem_read, pmem_write};
      if (cur == 2'b00) kcnt = 0;
      else if (cur != last_kind) kcnt = 1;
      else kcnt++;
      last_kind = cur;
      pmem_resp = (cur == 2'b10) ? (kcnt == fill_delay) :
                  (cur == 2'b01) ? (kcnt == wb_delay) : 1'b0;
    end
    #2;
    monitor();
  endtask

  task automatic do_access(input bit rd, input bit wr, input logic [6:0] a,
                           input int lat, input int rdc, input int wrc);
    sb_t e;
    int  n0;
    bit  got;
    tick();
    addr = a;
    mem_read = rd;
    mem_write = wr;
    e.start = cyc; e.lat = lat; e.rdc = rdc; e.wrc = wrc; e.is_write = wr;
    sb.push_back(e);
    n0 = resp_cnt;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      got = (resp_cnt != n0);
    end
    chk("resp_timeout", 32'(got), 1);
    if (!got) sb.delete();
    tick();
    mem_read = 1'b0;
    mem_write = 1'b0;
    chk("hit_count", 32'(hit_count), 32'(exp_hit));
    chk("miss_count", 32'(miss_count), 32'(exp_miss));
  endtask

  task automatic wait_pmem_read();
    bit seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = pmem_read;
    end
    chk("pmem_read_seen", 32'(seen), 1);
  endtask

  initial begin
    // {rd, wr, addr={tag,idx}, latency, fill cycles, wb cycles, hit+, miss+}
    vecs[0] = '{1, 0, {4'd1, 3'd0}, 5, 3, 0, 0, 1};
    vecs[1] = '{1, 0, {4'd1, 3'd0}, 1, 0, 0, 1, 0};
    vecs[2] = '{0, 1, {4'd1, 3'd0}, 1, 0, 0, 1, 0};
    vecs[3] = '{0, 1, {4'd2, 3'd0}, 7, 3, 2, 0, 1};
    vecs[4] = '{1, 0, {4'd2, 3'd1}, 5, 3, 0, 0, 1};
    vecs[5] = '{1, 0, {4'd2, 3'd0}, 1, 0, 0, 1, 0};
    vecs[6] = '{0, 1, {4'd2, 3'd1}, 1, 0, 0, 1, 0};
    vecs[7] = '{1, 0, {4'd5, 3'd1}, 7, 3, 2, 0, 1};
    vecs[8] = '{1, 1, {4'd5, 3'd1}, 1, 0, 0, 1, 0};
    vecs[9] = '{1, 0, {4'd5, 3'd1}, 1, 0, 0, 1, 0};

    #1 rst = 1'b1;
    #1;
    chk("reset_strobes", 32'(w_strb), 0);
    chk("reset_hit_count", 32'(hit_count), 0);
    chk("reset_miss_count", 32'(miss_count), 0);
    tick();
    tick();
    rst = 1'b0;
    model_clr = 1'b0;

    foreach (vecs[i]) begin
      exp_hit  = sat(exp_hit + vecs[i].hit_inc);
      exp_miss = sat(exp_miss + vecs[i].miss_inc);
      do_access(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].lat, vecs[i].rdc, vecs[i].wrc);
    end

    // Request dropped mid-fill: fill completes, no response, next access is a first-try hit.
    tick();
    addr = {4'd7, 3'd3};
    mem_read = 1'b1;
    wait_pmem_read();
    tick();
    mem_read = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    exp_miss = sat(exp_miss + 1);
    chk("drop_miss_count", 32'(miss_count), 32'(exp_miss));
    chk("drop_hit_count", 32'(hit_count), 32'(exp_hit));
    chk("drop_line_filled", 32'({dm_valid[3], dm_tag[3]}), 32'({1'b1, 4'd7}));
    exp_hit = sat(exp_hit + 1);
    do_access(1, 0, {4'd7, 3'd3}, 1, 0, 0);

    // Miss counter saturation, then hit counter saturation.
    for (int k = 0; k < 4; k++) begin
      logic [2:0] idx;
      idx = (k == 0) ? 3'd2 : 3'(k + 4);
      exp_miss = sat(exp_miss + 1);
      do_access(1, 0, {4'd3, idx}, 5, 3, 0);
    end
    for (int k = 0; k < 2; k++) begin
      exp_hit = sat(exp_hit + 1);
      do_access(1, 0, {4'd3, 3'd2}, 1, 0, 0);
    end

    // Reset during FILL with a late pmem_resp afterwards.
    auto_resp = 1'b0;
    pmem_resp = 1'b0;
    tick();
    addr = {4'd9, 3'd4};
    mem_read = 1'b1;
    wait_pmem_read();
    tick();
    rst = 1'b1;
    #1;
    chk("rst_pmem_read_drop", 32'(pmem_read), 0);
    chk("rst_strobes", 32'(w_strb), 0);
    chk("rst_hit_count", 32'(hit_count), 0);
    chk("rst_miss_count", 32'(miss_count), 0);
    mem_read = 1'b0;
    tick();
    rst = 1'b0;
    pmem_resp = 1'b1;
    #1;
    chk("late_resp_strobes", 32'(w_strb), 0);
    tick();
    pmem_resp = 1'b0;
    chk("late_resp_no_fill", 32'(dm_valid[4]), 0);
    last_kind = 2'b00;
    kcnt = 0;
    auto_resp = 1'b1;
    exp_hit = 0;
    exp_miss = 1;
    do_access(1, 0, {4'd9, 3'd4}, 5, 3, 0);

    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
